dma_byte_reader: RTL

//  Upstream stage of byte_fifo in the stream-based DMA test path. On a start command it reads
//  a byte-addressed, byte-length region from a 32-bit word memory. It keeps one read outstanding
//  at a time, unpacks each word little-endian and emits it as a valid/ready byte stream that

---
 rtl/dma_byte_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dma_byte_reader.sv
// Purpose : reads a byte-addressed, byte-length region from 32-bit word memory and streams it out as bytes.
// Latency : per word one REQ cycle (plus grant wait), one WAIT cycle (plus read latency), then one cycle per byte.
// Backpres: m_ready=0 holds m_valid/m_data in EMIT; mem_gnt=0 holds mem_req/mem_addr in REQ.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start, src_addr, len       command; accepted only while busy=0
//   busy, done                 status; done is a one-cycle pulse at completion
//   mem_req/mem_addr/mem_gnt   word read request channel, one outstanding read at most
//   mem_rvalid/mem_rdata       read response; byte lane k = bits [8k+7:8k]
//   m_valid/m_data/m_ready     output byte stream, ascending byte address order
module dma_byte_reader #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-3:0] word_addr, word_addr_nxt;
  logic [1:0]        lane, lane_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [31:0]       word_buf, word_buf_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      word_addr <= '0;
      lane      <= '0;
      remaining <= '0;
      word_buf  <= '0;
    end else begin
      state     <= state_nxt;
      word_addr <= word_addr_nxt;
      lane      <= lane_nxt;
      remaining <= remaining_nxt;
      word_buf  <= word_buf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    word_addr_nxt = word_addr;
    lane_nxt      = lane;
    remaining_nxt = remaining;
    word_buf_nxt  = word_buf;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            word_addr_nxt = src_addr[ADDR_W-1:2];
            lane_nxt      = src_addr[1:0];
            remaining_nxt = len;
            state_nxt     = S_REQ;
          end else begin
            // Zero-length command completes without touching memory.
            state_nxt = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          word_buf_nxt = mem_rdata;
          state_nxt    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          remaining_nxt = remaining - LEN_W'(1);
          lane_nxt      = lane + 2'd1;
          if (remaining == LEN_W'(1)) begin
            // Last byte: any lanes left in this word are dropped.
            state_nxt = S_DONE;
          end else if (lane == 2'd3) begin
            // Word exhausted; the word address wraps freely at the top of memory.
            word_addr_nxt = word_addr + (ADDR_W-2)'(1);
            state_nxt     = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // All outputs decode straight from registered state, so they are glitch-free
  // and hold steady across stalls without extra holding logic.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    mem_req  = (state == S_REQ);
    m_valid  = (state == S_EMIT);
    mem_addr = word_addr;
    m_data   = word_buf[{lane, 3'b000} +: 8];
  end

endmodule
